me_ctrl: RTL and testbench
==========================

Name: me_ctrl

Overview:
Sequencer for the full-search motion-estimation datapath (systolic SAD array fed by the current-MB and search-window BRAM banks).
- Loads the current macroblock, then walks every horizontal candidate offset.
- For each offset, streams the search-window rows with the bank address and rotation amount.
- Collects the vertical-offset SADs returned by the array and tracks the minimum SAD and its motion vector.
- Sits between the frame-level inter-prediction control (start/done) and the ME array plus its BRAMs.

Parameters:
MACRO_DIM, 16, macroblock edge in pixels
SEARCH_DIM, 48, search-window edge in pixels
ADDR_W, 8, BRAM address width; must hold (SEARCH_DIM/MACRO_DIM)*SEARCH_DIM-1
SAD_W, 16, SAD width
Derived: PORT_WIDTH=MACRO_DIM+1; NX=NY=SEARCH_DIM-MACRO_DIM+1 (33); RANGE=(NX-1)/2 (16)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  request one search; accepted only in IDLE
busy  out  1  high from the cycle after start is accepted until done
addr  out  ADDR_W  shared read address to current-MB and search BRAMs
amt  out  6  search-bank rotation amount
cur_load  out  1  array captures pixel_cpr_in column at addr
pass_start  out  1  one-cycle pulse; array clears its accumulators
spr_valid  out  1  pixel_spr_in at addr is a valid search row
sad_in  in  SAD_W  SAD from array
sad_valid  in  1  sad_in valid; NY pulses per pass, in vertical-offset order 0..NY-1
min_sad  out  SAD_W  best SAD of the last completed search
mv_x  out  6  signed best horizontal MV, -RANGE..+RANGE
mv_y  out  6  signed best vertical MV
done  out  1  one-cycle pulse; min_sad/mv valid from this cycle until the next start

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; min_sad=0; counters cleared.
- FSM states: IDLE, LOAD_CUR, PASS_INIT, STREAM, DRAIN, FINISH.
- IDLE:
  - start=1 -> LOAD_CUR and clear col counter c.
  - Set running best to all-ones and clear x.
  - sad_valid is ignored.
- LOAD_CUR: MACRO_DIM cycles; addr=c (0..MACRO_DIM-1), cur_load=1, amt=0. After c=MACRO_DIM-1 -> PASS_INIT.
- PASS_INIT:
  - One cycle; pass_start=1 and clear row counter r and SAD counter y.
  - Next state is STREAM.
- STREAM:
  - Runs SEARCH_DIM cycles with spr_valid=1.
  - addr=(x/PORT_WIDTH)*SEARCH_DIM+r and amt=x%PORT_WIDTH; both registered outputs.
  - After r=SEARCH_DIM-1 -> DRAIN.
  - sad_valid is accepted during STREAM as well.
- DRAIN:
  - spr_valid=0; wait until y reaches NY.
  - Then, if x=NX-1 -> FINISH; else x++ -> PASS_INIT. Passes never overlap.
- SAD compare, on every accepted sad_valid:
  - If sad_in < best (strict), update best, bx=x and by=y; then y++.
  - Ties keep the earlier candidate (x-major, then y).
  - sad_valid pulses beyond NY in one pass are ignored.
- FINISH:
  - One cycle; load min_sad=best, mv_x=bx-RANGE, mv_y=by-RANGE (6-bit two's complement).
  - Pulse done, busy=0 and go to IDLE.
  - Outputs hold until the next FINISH.
- start while busy: ignored, with no restart.
- rst mid-operation: immediate return to IDLE, all outputs 0, no done.
- Cycle count from start to done with a datapath of SAD latency L after the last row is MACRO_DIM + NX*(1+SEARCH_DIM+D) + 1, where D is the drain wait (≥0).

Test Plan:
- Reset check: assert rst mid-cycle -> all outputs 0 immediately; IDLE with no start for 20 cycles -> busy=0, done=0.
- Address sequence, with a bench scoreboard on addr/amt per pass:
  - LOAD_CUR gives addr 0..15 with cur_load.
  - Pass x=16 gives amt=16, addr 0..47.
  - Pass x=17 gives amt=0, addr 48..95.
  - Pass x=32 gives amt=15, addr 48..95.
  - pass_start pulses exactly 33 times.
- Full search: model returns sad=100+|mvx-3|+|mvy+5| after latency 5 -> done once, min_sad=100, mv_x=3, mv_y=-5 (6'h3B).
- Tie: model returns constant 500 -> min_sad=500, mv_x=-16, mv_y=-16.
- Robustness:
  - start pulsed during STREAM -> ignored, single done.
  - Extra sad_valid in IDLE and a 34th pulse in one pass -> ignored, result unchanged.
  - Minimum candidate at mv (16,16) with value 0 -> min_sad=0, mv (16,16).
- Reset mid-operation: assert rst in pass x=10 -> IDLE, no done. A new start then completes normally with the correct result and no stale best from the aborted run.

Source files
------------

// File: rtl/me_ctrl.sv
// Full-search motion-estimation sequencer: loads the current MB, streams the search
// window one horizontal offset per pass and keeps the minimum SAD and its motion vector.
module me_ctrl #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int ADDR_W     = 8,
  parameter int SAD_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [5:0]        amt,
  output logic              cur_load,
  output logic              pass_start,
  output logic              spr_valid,
  input  logic [SAD_W-1:0]  sad_in,
  input  logic              sad_valid,
  output logic [SAD_W-1:0]  min_sad,
  output logic [5:0]        mv_x,
  output logic [5:0]        mv_y,
  output logic              done
);

  localparam int PORT_WIDTH = MACRO_DIM + 1;
  localparam int NX         = SEARCH_DIM - MACRO_DIM + 1;
  localparam int NY         = NX;
  localparam int RANGE      = (NX - 1) / 2;
  localparam int CW         = $clog2(SEARCH_DIM + 1);
  localparam int XW         = $clog2(NX + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_CUR, PASS_INIT, STREAM, DRAIN, FINISH
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     c_q, r_q;
  logic [XW-1:0]     x_q, y_q, bx_q, by_q;
  logic [SAD_W-1:0]  best_q, min_sad_q;
  logic [ADDR_W-1:0] addr_q;
  logic [5:0]        amt_q, mv_x_q, mv_y_q;
  logic              busy_q, cur_load_q, pass_start_q, spr_valid_q, done_q;

  logic [ADDR_W-1:0] base_d;
  logic [5:0]        amt_d;
  logic              sad_take_d;

  // Bank base and rotation for the current horizontal offset.
  always_comb begin
    base_d     = ADDR_W'((int'(x_q) / PORT_WIDTH) * SEARCH_DIM);
    amt_d      = 6'(int'(x_q) % PORT_WIDTH);
    sad_take_d = sad_valid && (state_q == STREAM || state_q == DRAIN) &&
                 (y_q < XW'(NY));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      c_q          <= '0;
      r_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      best_q       <= '0;
      min_sad_q    <= '0;
      addr_q       <= '0;
      amt_q        <= '0;
      mv_x_q       <= '0;
      mv_y_q       <= '0;
      busy_q       <= 1'b0;
      cur_load_q   <= 1'b0;
      pass_start_q <= 1'b0;
      spr_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      pass_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          best_q <= '1;
          x_q    <= '0;
          if (start) begin
            state_q    <= LOAD_CUR;
            c_q        <= '0;
            addr_q     <= '0;
            amt_q      <= '0;
            cur_load_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD_CUR: begin
          if (c_q == CW'(MACRO_DIM - 1)) begin
            cur_load_q   <= 1'b0;
            pass_start_q <= 1'b1;
            state_q      <= PASS_INIT;
          end else begin
            c_q    <= c_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        PASS_INIT: begin
          r_q         <= '0;
          y_q         <= '0;
          addr_q      <= base_d;
          amt_q       <= amt_d;
          spr_valid_q <= 1'b1;
          state_q     <= STREAM;
        end
        STREAM: begin
          if (r_q == CW'(SEARCH_DIM - 1)) begin
            spr_valid_q <= 1'b0;
            state_q     <= DRAIN;
          end else begin
            r_q    <= r_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (y_q == XW'(NY)) begin
            if (x_q == XW'(NX - 1)) begin
              state_q <= FINISH;
            end else begin
              x_q          <= x_q + 1'b1;
              pass_start_q <= 1'b1;
              state_q      <= PASS_INIT;
            end
          end
        end
        FINISH: begin
          min_sad_q <= best_q;
          mv_x_q    <= 6'(int'(bx_q) - RANGE);
          mv_y_q    <= 6'(int'(by_q) - RANGE);
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Strict less-than keeps the earliest candidate on ties (x-major, then y).
      if (sad_take_d) begin
        if (sad_in < best_q) begin
          best_q <= sad_in;
          bx_q   <= x_q;
          by_q   <= y_q;
        end
        y_q <= y_q + 1'b1;
      end
    end
  end

  assign busy       = busy_q;
  assign addr       = addr_q;
  assign amt        = amt_q;
  assign cur_load   = cur_load_q;
  assign pass_start = pass_start_q;
  assign spr_valid  = spr_valid_q;
  assign min_sad    = min_sad_q;
  assign mv_x       = mv_x_q;
  assign mv_y       = mv_y_q;
  assign done       = done_q;

endmodule

// File: tb/tb_me_ctrl.sv
// Bench for me_ctrl: SAD-array model with latency, scoreboarded address streams and results.
module tb_me_ctrl;

  localparam int MD  = 16;
  localparam int SD  = 48;
  localparam int NX  = 33;
  localparam int NY  = 33;
  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, cur_load, pass_start, spr_valid, done, sad_valid;
  logic [7:0]  addr;
  logic [5:0]  amt, mv_x, mv_y;
  logic [15:0] sad_in, min_sad;

  always #5 clk = ~clk;

  me_ctrl #(.MACRO_DIM(16), .SEARCH_DIM(48), .ADDR_W(8), .SAD_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .addr(addr), .amt(amt),
    .cur_load(cur_load), .pass_start(pass_start), .spr_valid(spr_valid),
    .sad_in(sad_in), .sad_valid(sad_valid), .min_sad(min_sad),
    .mv_x(mv_x), .mv_y(mv_y), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int cur_q[$];
  int spr_q[$];
  int base_q[$];
  logic [27:0] res_q[$];
  int pass_cnt = 0;
  int done_cnt = 0;
  int cur_base = 0;
  int mode = 0;
  bit extra = 1'b0;
  int inj_req = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sad_of(input int m, input int x, input int y);
    int mx, my;
    mx = x - 16;
    my = y - 16;
    case (m)
      0:       return 100 + iabs(mx - 3) + iabs(my + 5);
      1:       return 500;
      2:       return (mx == 16 && my == 16) ? 0 : 1000;
      3:       return 50;
      default: return 200 + iabs(mx + 7) + iabs(my - 9);
    endcase
  endfunction

  // SAD array model: after a full pass of rows, returns NY SADs following LAT cycles.
  initial begin
    int rows, px, served;
    rows = 0; served = 0;
    sad_valid = 1'b0;
    sad_in = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rows = 0;
      end else if (inj_req != served) begin
        served++;
        sad_valid = 1'b1;
        sad_in = '0;
        @(negedge clk);
        sad_valid = 1'b0;
      end else if (spr_valid) begin
        rows++;
        if (rows == SD) begin
          rows = 0;
          px = pass_cnt - cur_base - 1;
          repeat (LAT) @(negedge clk);
          for (int y = 0; y < NY + (extra ? 1 : 0); y++) begin
            sad_valid = 1'b1;
            sad_in = (y < NY) ? 16'(sad_of(mode, px, y)) : 16'd0;
            @(negedge clk);
          end
          sad_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expected traffic whenever the DUT presents it.
  initial begin
    int e;
    logic [27:0] rr;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pass_start) pass_cnt++;
        if (cur_load) begin
          check("cur_expected", cur_q.size() > 0, 1);
          if (cur_q.size() > 0) begin
            e = cur_q.pop_front();
            check("cur_addr", addr, e);
            check("cur_amt", amt, 0);
            check("cur_busy", busy, 1);
          end
        end
        if (spr_valid) begin
          check("spr_expected", spr_q.size() > 0, 1);
          if (spr_q.size() > 0) begin
            e = spr_q.pop_front();
            check("spr_addr", addr, e / 64);
            check("spr_amt", amt, e % 64);
          end
        end
        if (done) begin
          done_cnt++;
          check("res_pending", res_q.size() > 0, 1);
          if (res_q.size() > 0) begin
            rr = res_q.pop_front();
            e = base_q.pop_front();
            check("min_sad", min_sad, rr[27:12]);
            check("mv_x", mv_x, rr[11:6]);
            check("mv_y", mv_y, rr[5:0]);
            check("pass_count", pass_cnt - e, NX);
            check("busy_at_done", busy, 0);
            check("stream_left", spr_q.size(), 0);
          end
        end
      end
    end
  end

  task automatic do_start(input int m, input logic [15:0] es, input logic [5:0] ex,
                          input logic [5:0] ey);
    mode = m;
    cur_base = pass_cnt;
    base_q.push_back(pass_cnt);
    for (int a = 0; a < MD; a++) cur_q.push_back(a);
    for (int x = 0; x < NX; x++)
      for (int r = 0; r < SD; r++)
        spr_q.push_back(((x / (MD + 1)) * SD + r) * 64 + (x % (MD + 1)));
    res_q.push_back({es, ex, ey});
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", done_cnt, target);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_amt"}, amt, 0);
    check({tag, "_cur_load"}, cur_load, 0);
    check({tag, "_pass_start"}, pass_start, 0);
    check({tag, "_spr_valid"}, spr_valid, 0);
    check({tag, "_min_sad"}, min_sad, 0);
    check({tag, "_mv_x"}, mv_x, 0);
    check({tag, "_mv_y"}, mv_y, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_done_cnt", done_cnt, 0);

    do_start(0, 16'd100, 6'd3, 6'h3B);
    wait_done(1);
    repeat (3) @(negedge clk);
    check("post_busy", busy, 0);
    check("post_done", done, 0);

    do_start(1, 16'd500, 6'h30, 6'h30);
    wait_done(2);

    do_start(2, 16'd0, 6'd16, 6'd16);
    wait_done(3);

    // Junk SAD in IDLE, a 34th SAD per pass, and a start while streaming.
    inj_req++;
    repeat (4) @(negedge clk);
    extra = 1'b1;
    do_start(0, 16'd100, 6'd3, 6'h3B);
    n = 0;
    while (!spr_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("stream_seen", spr_valid, 1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(4);
    extra = 1'b0;
    repeat (100) @(negedge clk);
    check("single_done", done_cnt, 4);
    check("restart_busy", busy, 0);

    // Abort during pass x=10 of a run whose best would be 50.
    do_start(3, 16'd50, 6'h30, 6'h30);
    n = 0;
    while (!(spr_valid && (pass_cnt - cur_base) == 11) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("pass10_seen", pass_cnt - cur_base, 11);
    #2 rst = 1'b1;
    #1;
    check_zero("abort");
    cur_q.delete();
    spr_q.delete();
    res_q.delete();
    base_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_no_done", done_cnt, 4);
    check("abort_idle_busy", busy, 0);

    do_start(4, 16'd200, 6'h39, 6'd9);
    wait_done(5);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
